// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Shares one SRAM-style slave port between an instruction-fetch master and a
// load/store (data) master. At most one transaction is in flight at a time.
//
// Transaction life cycle:
//   IDLE : a requesting master is granted combinationally (addr_ok pulses);
//          its request fields are captured at the same edge.
//   ADDR : the captured request is presented on sram_*; leave on sram_addr_ok.
//   DATA : wait for sram_data_ok, forward it to the owning master only.
//
// Parameters
//   DATA_PRIO   1: data master wins every tie; 0: round-robin on ties.
//
// Ports
//   clk, resetn                      clock (rising edge), async active-low reset
//   inst_req/wr/size/addr/wdata/wstrb  fetch request
//   inst_addr_ok/data_ok/rdata         fetch response
//   data_req/wr/size/addr/wdata/wstrb  load/store request
//   data_addr_ok/data_ok/rdata         load/store response
//   sram_req/wr/size/addr/wdata/wstrb  request to the shared slave
//   sram_addr_ok/data_ok/rdata         slave response
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int DATA_PRIO = 1
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  input  logic [3:0]  inst_wstrb,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        sram_req,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  output logic [3:0]  sram_wstrb,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  // last_grant encoding: 0 = inst, 1 = data
  localparam logic LG_INST = 1'b0;
  localparam logic LG_DATA = 1'b1;

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic        last_grant_q, last_grant_d;

  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic        gnt_inst;
  logic        gnt_data;
  logic        txn_done;

  // ---------------------------------------------------------------------------
  // Grant decision. Only IDLE grants, so the cycle in which sram_data_ok
  // returns (still DATA) never grants. Gating with resetn keeps addr_ok low
  // while reset is held even though the FSM already sits in IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_inst = 1'b0;
    gnt_data = 1'b0;
    if (resetn && (state_q == S_IDLE)) begin
      if (inst_req && data_req) begin
        if (DATA_PRIO != 0) begin
          gnt_data = 1'b1;
        end else if (last_grant_q == LG_INST) begin
          gnt_data = 1'b1;
        end else begin
          gnt_inst = 1'b1;
        end
      end else if (inst_req) begin
        gnt_inst = 1'b1;
      end else if (data_req) begin
        gnt_data = 1'b1;
      end
    end
  end

  // Completion is only recognised in DATA; a stray sram_data_ok elsewhere
  // (e.g. left over from a transaction abandoned by reset) is dropped.
  assign txn_done = (state_q == S_DATA) && sram_data_ok;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (gnt_inst || gnt_data) state_d = S_ADDR;
      S_ADDR: if (sram_addr_ok)         state_d = S_DATA;
      S_DATA: if (sram_data_ok)         state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture, ownership and round-robin history. Fields are loaded only
  // on a grant and otherwise held, which keeps sram_* stable for the whole
  // transaction (including any slave address stall).
  // ---------------------------------------------------------------------------
  always_comb begin
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;

    if (gnt_data) begin
      owner_d      = OWN_DATA;
      last_grant_d = LG_DATA;
      wr_d         = data_wr;
      size_d       = data_size;
      addr_d       = data_addr;
      wdata_d      = data_wdata;
      wstrb_d      = data_wstrb;
    end else if (gnt_inst) begin
      owner_d      = OWN_INST;
      last_grant_d = LG_INST;
      wr_d         = inst_wr;
      size_d       = inst_size;
      addr_d       = inst_addr;
      wdata_d      = inst_wdata;
      wstrb_d      = inst_wstrb;
    end else if (txn_done) begin
      owner_d      = OWN_NONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q      <= OWN_NONE;
      last_grant_q <= LG_INST;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
    end else begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    inst_addr_ok = gnt_inst;
    data_addr_ok = gnt_data;

    sram_req     = (state_q == S_ADDR);
    sram_wr      = wr_q;
    sram_size    = size_q;
    sram_addr    = addr_q;
    sram_wdata   = wdata_q;
    sram_wstrb   = wstrb_q;

    inst_data_ok = txn_done && (owner_q == OWN_INST);
    data_data_ok = txn_done && (owner_q == OWN_DATA);

    // Read data is broadcast; each master qualifies it with its own data_ok.
    inst_rdata   = sram_rdata;
    data_rdata   = sram_rdata;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for sram_arbiter. Two instances run side by side: index 0 with
// round-robin tie-break, index 1 with data priority. Each instance has its own
// masters and slave; only the reset is shared. A transaction-level model per
// instance predicts every output each cycle, and directed scenarios pin a few
// literal values.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic resetn;

  logic [1:0]        inst_req, inst_wr, data_req, data_wr;
  logic [1:0][1:0]   inst_size, data_size;
  logic [1:0][31:0]  inst_addr, inst_wdata, data_addr, data_wdata;
  logic [1:0][3:0]   inst_wstrb, data_wstrb;
  logic [1:0]        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [1:0][31:0]  inst_rdata, data_rdata;
  logic [1:0]        sram_req, sram_wr;
  logic [1:0][1:0]   sram_size;
  logic [1:0][31:0]  sram_addr, sram_wdata;
  logic [1:0][3:0]   sram_wstrb;
  logic [1:0]        sram_addr_ok, sram_data_ok;
  logic [1:0][31:0]  sram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_arbiter #(.DATA_PRIO(g)) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .inst_req     (inst_req[g]),
      .inst_wr      (inst_wr[g]),
      .inst_size    (inst_size[g]),
      .inst_addr    (inst_addr[g]),
      .inst_wdata   (inst_wdata[g]),
      .inst_wstrb   (inst_wstrb[g]),
      .inst_addr_ok (inst_addr_ok[g]),
      .inst_data_ok (inst_data_ok[g]),
      .inst_rdata   (inst_rdata[g]),
      .data_req     (data_req[g]),
      .data_wr      (data_wr[g]),
      .data_size    (data_size[g]),
      .data_addr    (data_addr[g]),
      .data_wdata   (data_wdata[g]),
      .data_wstrb   (data_wstrb[g]),
      .data_addr_ok (data_addr_ok[g]),
      .data_data_ok (data_data_ok[g]),
      .data_rdata   (data_rdata[g]),
      .sram_req     (sram_req[g]),
      .sram_wr      (sram_wr[g]),
      .sram_size    (sram_size[g]),
      .sram_addr    (sram_addr[g]),
      .sram_wdata   (sram_wdata[g]),
      .sram_wstrb   (sram_wstrb[g]),
      .sram_addr_ok (sram_addr_ok[g]),
      .sram_data_ok (sram_data_ok[g]),
      .sram_rdata   (sram_rdata[g])
    );
  end

  task automatic chk(input string nm, input int p, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h at %0t", nm, p, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level model: one optional outstanding transaction per
  // instance, whether the slave has accepted its address, who owns it, and
  // which master won the last grant.
  // ---------------------------------------------------------------------------
  bit          m_busy [2];
  bit          m_sent [2];
  bit          m_own  [2];   // 0 inst, 1 data
  bit          m_last [2];   // 0 inst, 1 data
  logic        m_wr   [2];
  logic [1:0]  m_size [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata[2];
  logic [3:0]  m_wstrb[2];

  // Returns {data_granted, inst_granted} for the current cycle.
  function automatic logic [1:0] exp_grant(input int p);
    logic [1:0] r;
    r = 2'b00;
    if (resetn === 1'b1 && !m_busy[p]) begin
      if (inst_req[p] && data_req[p])
        r = (p == 1 || !m_last[p]) ? 2'b10 : 2'b01;
      else if (data_req[p])
        r = 2'b10;
      else if (inst_req[p])
        r = 2'b01;
    end
    return r;
  endfunction

  always @(posedge clk or negedge resetn) begin
    for (int p = 0; p < 2; p++) begin
      if (!resetn) begin
        m_busy[p]  <= 1'b0;
        m_sent[p]  <= 1'b0;
        m_own[p]   <= 1'b0;
        m_last[p]  <= 1'b0;
        m_wr[p]    <= 1'b0;
        m_size[p]  <= 2'd0;
        m_addr[p]  <= 32'd0;
        m_wdata[p] <= 32'd0;
        m_wstrb[p] <= 4'd0;
      end else if (!m_busy[p]) begin
        if (exp_grant(p) == 2'b10) begin
          m_busy[p] <= 1'b1; m_sent[p] <= 1'b0; m_own[p] <= 1'b1; m_last[p] <= 1'b1;
          m_wr[p] <= data_wr[p]; m_size[p] <= data_size[p]; m_addr[p] <= data_addr[p];
          m_wdata[p] <= data_wdata[p]; m_wstrb[p] <= data_wstrb[p];
        end else if (exp_grant(p) == 2'b01) begin
          m_busy[p] <= 1'b1; m_sent[p] <= 1'b0; m_own[p] <= 1'b0; m_last[p] <= 1'b0;
          m_wr[p] <= inst_wr[p]; m_size[p] <= inst_size[p]; m_addr[p] <= inst_addr[p];
          m_wdata[p] <= inst_wdata[p]; m_wstrb[p] <= inst_wstrb[p];
        end
      end else if (!m_sent[p]) begin
        if (sram_addr_ok[p]) m_sent[p] <= 1'b1;
      end else if (sram_data_ok[p]) begin
        m_busy[p] <= 1'b0;
        m_sent[p] <= 1'b0;
      end
    end
  end

  // Compare every output of both instances on every falling edge.
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      chk("inst_addr_ok", p, 32'(inst_addr_ok[p]), 32'(exp_grant(p) == 2'b01));
      chk("data_addr_ok", p, 32'(data_addr_ok[p]), 32'(exp_grant(p) == 2'b10));
      chk("sram_req", p, 32'(sram_req[p]), 32'(resetn && m_busy[p] && !m_sent[p]));
      chk("inst_data_ok", p, 32'(inst_data_ok[p]),
          32'(resetn && m_busy[p] && m_sent[p] && sram_data_ok[p] && !m_own[p]));
      chk("data_data_ok", p, 32'(data_data_ok[p]),
          32'(resetn && m_busy[p] && m_sent[p] && sram_data_ok[p] && m_own[p]));
      chk("inst_rdata", p, inst_rdata[p], sram_rdata[p]);
      chk("data_rdata", p, data_rdata[p], sram_rdata[p]);
      if (resetn !== 1'b1) begin
        chk("rst_sram_fields", p,
            {sram_addr[p] | sram_wdata[p]} | 32'({sram_wr[p], sram_size[p], sram_wstrb[p]}), 32'd0);
      end else if (m_busy[p]) begin
        chk("sram_wr", p, 32'(sram_wr[p]), 32'(m_wr[p]));
        chk("sram_size", p, 32'(sram_size[p]), 32'(m_size[p]));
        chk("sram_addr", p, sram_addr[p], m_addr[p]);
        chk("sram_wdata", p, sram_wdata[p], m_wdata[p]);
        chk("sram_wstrb", p, 32'(sram_wstrb[p]), 32'(m_wstrb[p]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = '0; inst_wr = '0; inst_size = '0; inst_addr = '0; inst_wdata = '0; inst_wstrb = '0;
    data_req = '0; data_wr = '0; data_size = '0; data_addr = '0; data_wdata = '0; data_wstrb = '0;
    sram_addr_ok = '0; sram_data_ok = '0; sram_rdata = '0;
  endtask

  task automatic rand_inst(input int p);
    inst_req[p] = 1'b1; inst_wr[p] = 1'($urandom_range(0, 1)); inst_size[p] = 2'($urandom_range(0, 2));
    inst_addr[p] = $urandom; inst_wdata[p] = $urandom; inst_wstrb[p] = 4'($urandom_range(0, 15));
  endtask

  task automatic rand_data(input int p);
    data_req[p] = 1'b1; data_wr[p] = 1'($urandom_range(0, 1)); data_size[p] = 2'($urandom_range(0, 2));
    data_addr[p] = $urandom; data_wdata[p] = $urandom; data_wstrb[p] = 4'($urandom_range(0, 15));
  endtask

  initial begin
    int n0, n1;
    logic [3:0] seq0;
    logic inst1_seen;
    logic [1:0] g_i, g_d;

    resetn = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Single read on the data-priority instance.
    data_req[1] = 1'b1; data_wr[1] = 1'b0; data_size[1] = 2'd2; data_addr[1] = 32'h1C00_0100;
    @(negedge clk);
    chk("rd_addr_ok", 1, 32'(data_addr_ok[1]), 32'd1);
    chk("rd_inst_addr_ok", 1, 32'(inst_addr_ok[1]), 32'd0);
    step(); data_req[1] = 1'b0; sram_addr_ok[1] = 1'b1;
    @(negedge clk);
    chk("rd_sram_req_c1", 1, 32'(sram_req[1]), 32'd1);
    chk("rd_sram_addr", 1, sram_addr[1], 32'h1C00_0100);
    chk("rd_sram_wr", 1, 32'(sram_wr[1]), 32'd0);
    step(); sram_addr_ok[1] = 1'b0;
    @(negedge clk);
    chk("rd_sram_req_c2", 1, 32'(sram_req[1]), 32'd0);
    chk("rd_early_data_ok", 1, 32'(data_data_ok[1]), 32'd0);
    step(); sram_data_ok[1] = 1'b1; sram_rdata[1] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rd_data_ok", 1, 32'(data_data_ok[1]), 32'd1);
    chk("rd_rdata", 1, data_rdata[1], 32'hDEAD_BEEF);
    chk("rd_inst_data_ok", 1, 32'(inst_data_ok[1]), 32'd0);
    step(); sram_data_ok[1] = 1'b0;
    @(negedge clk);
    chk("rd_sram_req_after", 1, 32'(sram_req[1]), 32'd0);

    // Write from the fetch master.
    step();
    inst_req[1] = 1'b1; inst_wr[1] = 1'b1; inst_size[1] = 2'd2; inst_addr[1] = 32'h1C00_0200;
    inst_wdata[1] = 32'h1234_5678; inst_wstrb[1] = 4'b0011;
    @(negedge clk);
    chk("wr_addr_ok", 1, 32'(inst_addr_ok[1]), 32'd1);
    step(); inst_req[1] = 1'b0; sram_addr_ok[1] = 1'b1;
    @(negedge clk);
    chk("wr_sram_wr", 1, 32'(sram_wr[1]), 32'd1);
    chk("wr_sram_wstrb", 1, 32'(sram_wstrb[1]), 32'd3);
    chk("wr_sram_wdata", 1, sram_wdata[1], 32'h1234_5678);
    step(); sram_addr_ok[1] = 1'b0; sram_data_ok[1] = 1'b1;
    @(negedge clk);
    chk("wr_inst_data_ok", 1, 32'(inst_data_ok[1]), 32'd1);
    chk("wr_data_data_ok", 1, 32'(data_data_ok[1]), 32'd0);
    step(); sram_data_ok[1] = 1'b0;

    // Slave address stall: five cycles without sram_addr_ok, then accept.
    data_req[1] = 1'b1; data_wr[1] = 1'b1; data_size[1] = 2'd2; data_addr[1] = 32'h1C00_0300;
    data_wdata[1] = 32'hA5A5_5A5A; data_wstrb[1] = 4'b1111;
    @(negedge clk);
    chk("stall_addr_ok", 1, 32'(data_addr_ok[1]), 32'd1);
    step(); data_req[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sram_addr_ok[1] = (i == 5);
      @(negedge clk);
      chk("stall_sram_req", 1, 32'(sram_req[1]), 32'd1);
      chk("stall_sram_addr", 1, sram_addr[1], 32'h1C00_0300);
      chk("stall_sram_wdata", 1, sram_wdata[1], 32'hA5A5_5A5A);
      chk("stall_sram_wstrb", 1, 32'(sram_wstrb[1]), 32'hF);
      chk("stall_no_ok", 1, 32'({inst_addr_ok[1], data_addr_ok[1], inst_data_ok[1], data_data_ok[1]}), 32'd0);
      step();
    end
    sram_addr_ok[1] = 1'b0; sram_data_ok[1] = 1'b1;
    @(negedge clk);
    chk("stall_data_ok", 1, 32'(data_data_ok[1]), 32'd1);
    step(); sram_data_ok[1] = 1'b0;

    // Reset while waiting for slave data, with a late sram_data_ok.
    data_req[1] = 1'b1; data_wr[1] = 1'b0; data_addr[1] = 32'h1C00_0400;
    @(negedge clk);
    step(); data_req[1] = 1'b0; sram_addr_ok[1] = 1'b1;
    @(negedge clk);
    step(); sram_addr_ok[1] = 1'b0;
    @(negedge clk);
    #1 resetn = 1'b0;
    inst_req[1] = 1'b1; data_req[1] = 1'b1; sram_data_ok[1] = 1'b1;
    step();
    @(negedge clk);
    chk("rst_addr_ok", 1, 32'({inst_addr_ok[1], data_addr_ok[1]}), 32'd0);
    chk("rst_data_ok", 1, 32'({inst_data_ok[1], data_data_ok[1]}), 32'd0);
    chk("rst_sram_req", 1, 32'(sram_req[1]), 32'd0);
    chk("rst_sram_addr", 1, sram_addr[1], 32'd0);
    step(); resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", 1, 32'(data_addr_ok[1]), 32'd1);
    chk("post_rst_late_ok", 1, 32'({inst_data_ok[1], data_data_ok[1]}), 32'd0);
    step(); inst_req[1] = 1'b0; data_req[1] = 1'b0; sram_data_ok[1] = 1'b0; sram_addr_ok[1] = 1'b1;
    @(negedge clk);
    step(); sram_addr_ok[1] = 1'b0; sram_data_ok[1] = 1'b1;
    @(negedge clk);
    chk("post_rst_data_ok", 1, 32'(data_data_ok[1]), 32'd1);
    step(); sram_data_ok[1] = 1'b0;

    // Both masters requesting continuously, zero-wait slaves, on both instances.
    for (int p = 0; p < 2; p++) begin
      inst_req[p] = 1'b1; inst_addr[p] = 32'h0000_1000; inst_wr[p] = 1'b0;
      data_req[p] = 1'b1; data_addr[p] = 32'h0000_2000; data_wr[p] = 1'b0;
      sram_addr_ok[p] = 1'b1; sram_data_ok[p] = 1'b1;
    end
    n0 = 0; n1 = 0; seq0 = '0; inst1_seen = 1'b0;
    for (int c = 0; c < 40 && (n0 < 4 || n1 < 4); c++) begin
      @(negedge clk);
      if ((inst_addr_ok[0] || data_addr_ok[0]) && n0 < 4) begin
        seq0[n0] = data_addr_ok[0];
        n0++;
      end
      if ((inst_addr_ok[1] || data_addr_ok[1]) && n1 < 4) begin
        if (inst_addr_ok[1]) inst1_seen = 1'b1;
        n1++;
      end
      step();
    end
    chk("rr_count", 0, 32'(n0), 32'd4);
    chk("rr_order", 0, 32'(seq0), 32'b0101);
    chk("prio_count", 1, 32'(n1), 32'd4);
    chk("prio_inst_granted", 1, 32'(inst1_seen), 32'd0);
    inst_req = '0; data_req = '0;
    repeat (4) step();
    sram_addr_ok = '0; sram_data_ok = '0;

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      g_i = inst_addr_ok;
      g_d = data_addr_ok;
      step();
      resetn = ($urandom_range(0, 299) != 0);
      for (int p = 0; p < 2; p++) begin
        if (inst_req[p] && g_i[p]) inst_req[p] = 1'b0;
        if (data_req[p] && g_d[p]) data_req[p] = 1'b0;
        if (!inst_req[p] && $urandom_range(0, 2) == 0) rand_inst(p);
        if (!data_req[p] && $urandom_range(0, 2) == 0) rand_data(p);
        sram_addr_ok[p] = ($urandom_range(0, 2) != 0);
        sram_data_ok[p] = ($urandom_range(0, 1) != 0);
        sram_rdata[p]   = $urandom;
      end
    end
    resetn = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter DATA_PRIO, default 1; 1 = data master always wins a tie, 0 = round-robin tie-break.
REQ-002 SHALL have port clk, input, 1; the single clock, rising edge.
REQ-003 SHALL have port resetn, input, 1; reset, asynchronous, active-low.
REQ-004 SHALL have inst master inputs inst_req 1, inst_wr 1, inst_size 2, inst_addr 32, inst_wdata 32, inst_wstrb 4; the fetch request.
REQ-005 SHALL have inst master outputs inst_addr_ok 1, inst_data_ok 1, inst_rdata 32; the fetch response.
REQ-006 SHALL have data master inputs data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb, with the same widths as REQ-004; the load/store request.
REQ-007 SHALL have data master outputs data_addr_ok, data_data_ok, data_rdata, with the same widths as REQ-005.
REQ-008 SHALL have slave outputs sram_req, sram_wr, sram_size, sram_addr, sram_wdata, sram_wstrb, with the same widths as REQ-004; the shared SRAM port.
REQ-009 SHALL have slave inputs sram_addr_ok 1, sram_data_ok 1, sram_rdata 32.

Function
REQ-010 SHALL run a 3-state FSM: IDLE, ADDR (address phase to slave), DATA (awaiting slave data).
REQ-011 SHALL allow at most one outstanding transaction.
REQ-012 SHALL, in IDLE with at least one master req=1, grant exactly one master combinationally.
- Only inst_req: grant inst. Only data_req: grant data.
- Both, DATA_PRIO=1: grant data.
- Both, DATA_PRIO=0: grant the master that is not last_grant.
REQ-013 SHALL drive the granted master's addr_ok=1 in that IDLE cycle.
- At the same edge: latch the granted wr/size/addr/wdata/wstrb, update last_grant, go to ADDR.
REQ-014 SHALL drive addr_ok=0 for both masters in ADDR and DATA, and for the losing master in IDLE.
REQ-015 SHALL, in ADDR, drive sram_req=1 with the latched fields.
- Stay in ADDR until sram_addr_ok=1 at an edge, then go to DATA.
REQ-016 SHALL hold sram_* fields stable for the whole transaction; sram_req SHALL be 0 outside ADDR.
REQ-017 SHALL, in DATA with sram_data_ok=1, drive the owner's data_ok=1 for that cycle, with its rdata = sram_rdata, and go to IDLE at the edge.
REQ-018 SHALL ignore sram_data_ok in IDLE and ADDR; no master data_ok is produced.
REQ-019 SHALL keep the non-owner's data_ok at 0 at all times.
REQ-020 SHALL drive inst_rdata and data_rdata = sram_rdata at all times; only data_ok qualifies them.
REQ-021 SHALL not grant in the cycle sram_data_ok returns; the next grant occurs in IDLE one cycle later.
- Minimum throughput: one transaction per 3 cycles.
REQ-022 SHALL leave an ungranted master's request pending, with no loss and no addr_ok, until a later IDLE grant.
REQ-023 SHALL treat reads and writes identically; a write also completes on sram_data_ok.

Reset
REQ-024 SHALL, on resetn=0, immediately and asynchronously set FSM=IDLE, last_grant=inst, owner=none and all latched fields=0.
REQ-025 SHALL hold all outputs at 0 during reset (rdata outputs follow sram_rdata).
REQ-026 SHALL abandon any in-flight transaction on reset mid-operation; a late sram_data_ok after release is ignored per REQ-018.
REQ-027 SHALL accept a grant in the first IDLE cycle after resetn rises.

Verification
REQ-028 Single read: data_req=1, data_wr=0, addr=0x1C000100; slave addr_ok in 1 cycle, data_ok 2 cycles later with rdata=0xDEADBEEF.
- Required: data_addr_ok in cycle 0, sram_req in cycle 1 only, data_data_ok=1 with data_rdata=0xDEADBEEF; inst_* ok signals stay 0.
REQ-029 Tie, DATA_PRIO=1: both req held continuously, zero-wait slave.
- Required: data granted every transaction; inst never granted while data_req=1.
REQ-030 Tie, DATA_PRIO=0: both req held, 4 transactions.
- Required: grant order data, inst, data, inst.
REQ-031 Slave stall: sram_addr_ok held 0 for 5 cycles, then 1.
- Required: sram_req=1 and sram_addr/wdata/wstrb unchanged for 6 cycles; no master ok pulses.
REQ-032 Write: inst_req=1, inst_wr=1, wstrb=4'b0011, wdata=0x12345678.
- Required: sram_wr=1, sram_wstrb=0011, sram_wdata=0x12345678; inst_data_ok pulses on sram_data_ok.
REQ-033 Reset mid-op: resetn=0 while in DATA, then released; slave asserts sram_data_ok.
- Required: all outputs 0 during reset, no data_ok to either master; the next request is granted normally.
